// File: rtl/pll_lock_sequencer.sv
// Power-up / lock-loss sequencer for the iCE40 PLL, running on the 12 MHz reference.
// Holds the PLL in reset, waits for a steady lock, then releases the system reset; retries, then faults.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 16,
    parameter int MAX_RETRIES   = 3,
    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic            clock_in,
    input  logic            resetb,
    input  logic            locked,
    input  logic            restart,
    output logic            pll_resetb,
    output logic            sys_reset_n,
    output logic            fault,
    output logic [RC_W-1:0] retry_count
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_ASSERT_RST = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  retry_q, retry_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_resetb_q, pll_resetb_d;
    logic             sys_reset_n_q, sys_reset_n_d;
    logic             fault_q, fault_d;
    logic             fail_s;

    // Two-flop synchronizer for the asynchronous PLL lock signal.
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state, shared counter, retry budget and next output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        fail_s  = 1'b0;
        if (restart) begin
            state_d = ST_ASSERT_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_ASSERT_RST: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        fail_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    // A dropout here only restarts the lock wait; it does not spend a retry.
                    if (!lock_s_q) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        fail_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_ASSERT_RST;
                    cnt_d   = '0;
                end
            endcase
            if (fail_s) begin
                cnt_d = '0;
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + RC_W'(1);
                    state_d = ST_ASSERT_RST;
                end else begin
                    state_d = ST_FAULT;
                end
            end else begin
                retry_d = retry_q;
            end
        end
        pll_resetb_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
        sys_reset_n_d = (state_d == ST_RUN);
        fault_d       = (state_d == ST_FAULT);
    end

    // State, counter, retry count and registered outputs.
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            state_q       <= ST_ASSERT_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_resetb_q  <= 1'b0;
            sys_reset_n_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_resetb_q  <= pll_resetb_d;
            sys_reset_n_q <= sys_reset_n_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign sys_reset_n = sys_reset_n_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus randomized lock
// behaviour, every edge compared against a phase/age reference model.
module tb_pll_lock_sequencer;

    localparam int RST_N = 4;
    localparam int TO_N  = 20;
    localparam int ST_N  = 16;
    localparam int MAXR  = 3;

    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STAB = 2;
    localparam int M_RUN  = 3;
    localparam int M_FLT  = 4;

    logic       clock_in;
    logic       resetb;
    logic       locked;
    logic       restart;
    logic       pll_resetb;
    logic       sys_reset_n;
    logic       fault;
    logic [1:0] retry_count;

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;

    int m_phase = M_RST;
    int m_age   = 0;
    int m_fails = 0;
    bit lq[$];

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_N),
        .LOCK_TIMEOUT (TO_N),
        .STABLE_CYCLES(ST_N),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .clock_in   (clock_in),
        .resetb     (resetb),
        .locked     (locked),
        .restart    (restart),
        .pll_resetb (pll_resetb),
        .sys_reset_n(sys_reset_n),
        .fault      (fault),
        .retry_count(retry_count)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = M_RST;
        m_age   = 0;
        m_fails = 0;
        lq      = {1'b0, 1'b0};
    endfunction

    // One clock edge of the reference: m_age counts cycles completed in the current phase.
    function automatic void model_edge(input bit ls, input bit rs);
        bit failed;
        failed = 1'b0;
        if (rs) begin
            m_phase = M_RST;
            m_age   = 0;
            m_fails = 0;
            return;
        end
        m_age++;
        case (m_phase)
            M_RST:  if (m_age == RST_N) begin m_phase = M_WAIT; m_age = 0; end
            M_WAIT: if (ls) begin m_phase = M_STAB; m_age = 0; end
                    else if (m_age == TO_N) failed = 1'b1;
            M_STAB: if (!ls) begin m_phase = M_WAIT; m_age = 0; end
                    else if (m_age == ST_N) begin m_phase = M_RUN; m_age = 0; end
            M_RUN:  if (!ls) failed = 1'b1;
            default: ;
        endcase
        if (failed) begin
            m_age = 0;
            if (m_fails < MAXR) begin
                m_fails++;
                m_phase = M_RST;
            end else begin
                m_phase = M_FLT;
            end
        end
    endfunction

    task automatic check_model();
        bit exp_pll;
        exp_pll = (m_phase == M_WAIT) || (m_phase == M_STAB) || (m_phase == M_RUN);
        chk("pll_resetb", 32'(pll_resetb), 32'(exp_pll));
        chk("sys_reset_n", 32'(sys_reset_n), 32'(m_phase == M_RUN));
        chk("fault", 32'(fault), 32'(m_phase == M_FLT));
        chk("retry_count", 32'(retry_count), 32'(m_fails));
    endtask

    task automatic tick();
        bit ls;
        ls = lq.pop_front();
        lq.push_back(locked);
        model_edge(ls, restart);
        @(posedge clock_in);
        #1;
        edge_n++;
        check_model();
    endtask

    // Pulse resetb low between clock edges and restart the reference.
    task automatic do_reset();
        #4;
        resetb = 1'b0;
        #2;
        resetb = 1'b1;
        model_reset();
        edge_n = 0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        edge_n = 0;
    endtask

    task automatic wait_run(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sys_reset_n === 1'b1) begin
                at = edge_n;
                break;
            end
        end
    endtask

    initial begin
        int at;
        int pll_rise;
        int fault_at;
        int bad;
        int hold;

        resetb  = 1'b0;
        locked  = 1'b1;
        restart = 1'b0;
        model_reset();
        #12;
        chk("rst_pll_resetb", 32'(pll_resetb), 32'd0);
        chk("rst_sys_reset_n", 32'(sys_reset_n), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retry_count", 32'(retry_count), 32'd0);

        // Power-up with a constant lock.
        resetb = 1'b1;
        edge_n = 0;
        pll_rise = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pll_resetb === 1'b1) begin
                pll_rise = edge_n;
                break;
            end
        end
        chk("pwr_pll_rise_edge", 32'(pll_rise), 32'd4);
        wait_run(60, at);
        chk("pwr_run_edge", 32'(at), 32'd21);
        chk("pwr_retry_count", 32'(retry_count), 32'd0);
        chk("pwr_fault", 32'(fault), 32'd0);
        for (int i = 0; i < 5; i++) tick();

        // One-cycle lock dropout at STABLE count 10.
        do_reset();
        while (edge_n < 14) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        wait_run(100, at);
        chk("glitch_run_edge", 32'(at), 32'd34);
        chk("glitch_delay_ge12", 32'(at >= 33), 32'd1);
        chk("glitch_retry_count", 32'(retry_count), 32'd0);

        // Lock loss in RUN: system reset drops three edges later.
        for (int i = 0; i < 3; i++) tick();
        locked = 1'b0;
        tick();
        chk("loss_sys_e1", 32'(sys_reset_n), 32'd1);
        tick();
        chk("loss_sys_e2", 32'(sys_reset_n), 32'd1);
        tick();
        chk("loss_sys_e3", 32'(sys_reset_n), 32'd0);
        chk("loss_pll_e3", 32'(pll_resetb), 32'd0);
        chk("loss_retry_count", 32'(retry_count), 32'd1);
        locked = 1'b1;
        wait_run(100, at);
        chk("loss_rerun_reached", 32'(at > 0), 32'd1);
        chk("loss_rerun_retry_count", 32'(retry_count), 32'd1);

        // Restart while running.
        pulse_restart();
        chk("rs_run_pll", 32'(pll_resetb), 32'd0);
        chk("rs_run_sys", 32'(sys_reset_n), 32'd0);
        chk("rs_run_retry_count", 32'(retry_count), 32'd0);
        wait_run(60, at);
        chk("rs_run_bringup_edge", 32'(at), 32'd21);

        // No lock at all: four attempts, then FAULT.
        locked = 1'b0;
        do_reset();
        fault_at = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (edge_n == 24 || edge_n == 48 || edge_n == 72)
                chk("to_retry_step", 32'(retry_count), 32'(edge_n / 24));
            if (fault === 1'b1) begin
                fault_at = edge_n;
                break;
            end
        end
        chk("to_fault_edge", 32'(fault_at), 32'd96);
        chk("to_fault_retry_count", 32'(retry_count), 32'd3);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            locked = (i % 7 == 0);
            tick();
            if (fault !== 1'b1 || pll_resetb !== 1'b0) bad++;
        end
        chk("to_fault_hold_violations", 32'(bad), 32'd0);

        // Restart out of FAULT.
        locked = 1'b1;
        pulse_restart();
        chk("rs_flt_fault", 32'(fault), 32'd0);
        chk("rs_flt_retry_count", 32'(retry_count), 32'd0);
        wait_run(60, at);
        chk("rs_flt_bringup_edge", 32'(at), 32'd21);

        // Asynchronous reset in the middle of STABLE.
        pulse_restart();
        while (edge_n < 10) tick();
        chk("ar_pre_pll", 32'(pll_resetb), 32'd1);
        #4;
        resetb = 1'b0;
        #1;
        chk("ar_pll", 32'(pll_resetb), 32'd0);
        chk("ar_sys", 32'(sys_reset_n), 32'd0);
        chk("ar_fault", 32'(fault), 32'd0);
        chk("ar_retry_count", 32'(retry_count), 32'd0);
        #2;
        resetb = 1'b1;
        model_reset();
        edge_n = 0;
        wait_run(60, at);
        chk("ar_bringup_edge", 32'(at), 32'd21);

        // Randomized lock behaviour with occasional restarts.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                locked = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            restart = ($urandom_range(0, 199) == 0);
            tick();
        end
        restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
